// File: rtl/shcl_slot_sched.sv
// shcl_slot_sched: slot allocator and issue scheduler for the shared
// hash/scalar multiplier pipeline.
//
// Incoming tagged hashes are written into one slot of a 2^W_IN_MEM-entry
// input memory. Each slot is then issued N_STEPS times into the multiplier.
// Each slot has at most one pass in flight, and no more than MAX_INFLIGHT
// passes are in flight overall. Finished slots are presented on a
// registered output port. A slot is freed only after the consumer has
// taken it.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_hash_data/valid/ref/ready request channel (ready = ~rst & any FREE)
//   wr_valid/addr/data           slot-memory write, registered
//   mul_valid/addr/step          pass issue to the multiplier, registered
//   mul_ret_valid/addr           pass completion from the multiplier
//   out_valid/ready/addr/ref     finished-slot channel, registered
//   err                          sticky: a return arrived for a non-BUSY slot
//   dbg_inflight                 passes issued and not yet returned
//   dbg_slot_state               per-slot state, 3 bits per slot, slot 0 in LSBs
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The sender holds valid and its payload stable until that edge.
// in_hash_ready depends only on registered slot state and rst, never on
// in_hash_valid. out_valid never waits for out_ready. mul_valid and
// mul_ret_valid are single-cycle strobes with no back-pressure.
module shcl_slot_sched #(
  parameter int W_HASH       = 256,
  parameter int W_IN_MEM     = 6,
  parameter int W_T          = 16,
  parameter int MUL_D        = 15,
  parameter int N_STEPS      = 4,
  parameter int MAX_INFLIGHT = (MUL_D + 1) + 6,
  localparam int NSLOT       = 1 << W_IN_MEM,
  localparam int IFW         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_HASH-1:0]     in_hash_data,
  input  logic                  in_hash_valid,
  input  logic [W_T-1:0]        in_hash_ref,
  output logic                  in_hash_ready,
  output logic                  wr_valid,
  output logic [W_IN_MEM-1:0]   wr_addr,
  output logic [W_HASH-1:0]     wr_data,
  output logic                  mul_valid,
  output logic [W_IN_MEM-1:0]   mul_addr,
  output logic [7:0]            mul_step,
  input  logic                  mul_ret_valid,
  input  logic [W_IN_MEM-1:0]   mul_ret_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W_IN_MEM-1:0]   out_addr,
  output logic [W_T-1:0]        out_ref,
  output logic                  err,
  output logic [IFW-1:0]        dbg_inflight,
  output logic [3*NSLOT-1:0]    dbg_slot_state
);

  localparam logic [2:0] S_FREE  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [IFW-1:0] MAX_IF    = IFW'(MAX_INFLIGHT);
  localparam logic [7:0]     LAST_STEP = 8'(N_STEPS);

  // Per-slot bookkeeping.
  logic [2:0]          state_q [NSLOT];
  logic [2:0]          state_d [NSLOT];
  logic [7:0]          step_q  [NSLOT];
  logic [7:0]          step_d  [NSLOT];
  logic [W_T-1:0]      ref_q   [NSLOT];
  logic [W_T-1:0]      ref_d   [NSLOT];

  logic [IFW-1:0]      inflight_q, inflight_d;
  logic [W_IN_MEM-1:0] rr_issue_q, rr_issue_d;
  logic [W_IN_MEM-1:0] rr_out_q, rr_out_d;

  // Registered outputs.
  logic                wr_valid_q;
  logic [W_IN_MEM-1:0] wr_addr_q;
  logic [W_HASH-1:0]   wr_data_q;
  logic                mul_valid_q;
  logic [W_IN_MEM-1:0] mul_addr_q;
  logic [7:0]          mul_step_q;
  logic                out_valid_q;
  logic [W_IN_MEM-1:0] out_addr_q;
  logic [W_T-1:0]      out_ref_q;
  logic                err_q;

  // Slot selection results.
  logic                free_found, rdy_found, done_found;
  logic [W_IN_MEM-1:0] free_idx, rdy_idx, done_idx;
  logic [W_IN_MEM-1:0] cand_rdy, cand_done;

  // Events of this cycle.
  logic accept, issue, ret_ok, ret_bad, out_load, out_hs;

  // The lowest FREE slot is allocated. READY and DONE slots are searched
  // round-robin from their pointers. The additions wrap modulo NSLOT
  // because of the index width.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (state_q[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = W_IN_MEM'(i);
      end
    end
    rdy_found  = 1'b0;
    rdy_idx    = rr_issue_q;
    done_found = 1'b0;
    done_idx   = rr_out_q;
    cand_rdy   = '0;
    cand_done  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      cand_rdy  = rr_issue_q + W_IN_MEM'(i);
      cand_done = rr_out_q + W_IN_MEM'(i);
      if (!rdy_found && state_q[cand_rdy] == S_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = cand_rdy;
      end
      if (!done_found && state_q[cand_done] == S_DONE) begin
        done_found = 1'b1;
        done_idx   = cand_done;
      end
    end
  end

  assign in_hash_ready = ~rst & free_found;

  assign accept   = in_hash_valid & in_hash_ready;
  // The cap uses only registered inflight. A return arriving in the same
  // cycle does not open room for an issue until the next cycle.
  assign issue    = rdy_found & (inflight_q < MAX_IF);
  assign ret_ok   = mul_ret_valid & (state_q[mul_ret_addr] == S_BUSY);
  assign ret_bad  = mul_ret_valid & (state_q[mul_ret_addr] != S_BUSY);
  assign out_hs   = out_valid_q & out_ready;
  assign out_load = ~out_valid_q | out_ready;

  // Every event targets a slot in a different state: accept targets FREE,
  // issue READY, return BUSY, output load DONE and handshake DRAIN. So no
  // two events ever update the same slot in one cycle.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ref_d      = ref_q;
    rr_issue_d = rr_issue_q;
    rr_out_d   = rr_out_q;
    inflight_d = inflight_q;

    if (accept) begin
      state_d[free_idx] = S_READY;
      step_d[free_idx]  = 8'd0;
      ref_d[free_idx]   = in_hash_ref;
    end

    if (issue) begin
      state_d[rdy_idx] = S_BUSY;
      rr_issue_d       = rdy_idx + 1'b1;
    end

    if (ret_ok) begin
      step_d[mul_ret_addr]  = step_q[mul_ret_addr] + 8'd1;
      state_d[mul_ret_addr] = (step_q[mul_ret_addr] + 8'd1 == LAST_STEP) ? S_DONE : S_READY;
    end

    if (out_hs) begin
      state_d[out_addr_q] = S_FREE;
    end

    if (out_load && done_found) begin
      state_d[done_idx] = S_DRAIN;
      rr_out_d          = done_idx + 1'b1;
    end

    case ({issue, ret_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= S_FREE;
        step_q[i]  <= 8'd0;
        ref_q[i]   <= '0;
      end
      inflight_q <= '0;
      rr_issue_q <= '0;
      rr_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ref_q      <= ref_d;
      inflight_q <= inflight_d;
      rr_issue_q <= rr_issue_d;
      rr_out_q   <= rr_out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mul_valid_q <= 1'b0;
      mul_addr_q  <= '0;
      mul_step_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_ref_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_valid_q <= accept;
      if (accept) begin
        wr_addr_q <= free_idx;
        wr_data_q <= in_hash_data;
      end
      mul_valid_q <= issue;
      if (issue) begin
        mul_addr_q <= rdy_idx;
        mul_step_q <= step_q[rdy_idx];
      end
      // Address and tag load only on a load cycle. They therefore stay
      // frozen while out_valid is held against out_ready=0.
      if (out_load) begin
        out_valid_q <= done_found;
        if (done_found) begin
          out_addr_q <= done_idx;
          out_ref_q  <= ref_q[done_idx];
        end
      end
      err_q <= err_q | ret_bad;
    end
  end

  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign mul_valid    = mul_valid_q;
  assign mul_addr     = mul_addr_q;
  assign mul_step     = mul_step_q;
  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_ref      = out_ref_q;
  assign err          = err_q;
  assign dbg_inflight = inflight_q;

  for (genvar g = 0; g < NSLOT; g++) begin : g_dbg
    assign dbg_slot_state[3*g +: 3] = state_q[g];
  end

endmodule

// File: tb/tb_shcl_slot_sched.sv
// Testbench for shcl_slot_sched.
// The multiplier is modelled inside tick(): every issue seen on mul_valid is
// returned a fixed 16 cycles later while auto_ret is set. Tests can also
// schedule individual returns by hand. Expected outputs {addr, ref} go into
// exp_q when a request is driven, and are popped when out_valid shows up.
module tb_shcl_slot_sched;
  localparam int W_HASH = 256;
  localparam int W_IN_MEM = 6;
  localparam int W_T = 16;
  localparam int NSLOT = 64;
  localparam int MAXI = 22;
  localparam int IFW = $clog2(MAXI + 1);
  localparam logic [2:0] S_FREE = 3'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W_HASH-1:0] in_hash_data = '0;
  logic in_hash_valid = 1'b0;
  logic [W_T-1:0] in_hash_ref = '0;
  logic in_hash_ready;
  logic wr_valid;
  logic [W_IN_MEM-1:0] wr_addr;
  logic [W_HASH-1:0] wr_data;
  logic mul_valid;
  logic [W_IN_MEM-1:0] mul_addr;
  logic [7:0] mul_step;
  logic mul_ret_valid = 1'b0;
  logic [W_IN_MEM-1:0] mul_ret_addr = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W_IN_MEM-1:0] out_addr;
  logic [W_T-1:0] out_ref;
  logic err;
  logic [IFW-1:0] dbg_inflight;
  logic [3*NSLOT-1:0] dbg_slot_state;

  shcl_slot_sched dut (
    .clk(clk), .rst(rst),
    .in_hash_data(in_hash_data), .in_hash_valid(in_hash_valid),
    .in_hash_ref(in_hash_ref), .in_hash_ready(in_hash_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .mul_valid(mul_valid), .mul_addr(mul_addr), .mul_step(mul_step),
    .mul_ret_valid(mul_ret_valid), .mul_ret_addr(mul_ret_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_ref(out_ref), .err(err),
    .dbg_inflight(dbg_inflight), .dbg_slot_state(dbg_slot_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  bit auto_ret = 1'b0;
  int ret_due_q[$];
  logic [W_IN_MEM-1:0] ret_addr_q[$];
  int iss_cyc_q[$];
  int iss_addr_q[$];
  int iss_step_q[$];
  logic [W_IN_MEM+W_T-1:0] exp_q[$];
  logic [W_IN_MEM+8-1:0] exp_iss_q[$];

  // ---------------- driver tasks ----------------
  // Advance one cycle. Sampling and driving happen 1 time unit after the
  // rising edge. The multiplier model logs issues and drives due returns.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mul_valid === 1'b1) begin
      iss_cyc_q.push_back(cyc);
      iss_addr_q.push_back(int'(mul_addr));
      iss_step_q.push_back(int'(mul_step));
      if (auto_ret) begin
        ret_due_q.push_back(cyc + 16);
        ret_addr_q.push_back(mul_addr);
      end
    end
    mul_ret_valid = 1'b0;
    for (int i = 0; i < ret_due_q.size(); i++) begin
      if (ret_due_q[i] == cyc) begin
        mul_ret_valid = 1'b1;
        mul_ret_addr = ret_addr_q[i];
        ret_due_q.delete(i);
        ret_addr_q.delete(i);
        break;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sched_ret(input int due, input logic [W_IN_MEM-1:0] a);
    ret_due_q.push_back(due);
    ret_addr_q.push_back(a);
  endtask

  function automatic logic [W_HASH-1:0] rand_hash();
    logic [W_HASH-1:0] r;
    for (int i = 0; i < W_HASH / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Drive one request for a single cycle and push its expected output.
  task automatic drive_req(input logic [W_T-1:0] r, input logic [W_IN_MEM-1:0] exp_slot,
                           output logic [W_HASH-1:0] d);
    d = rand_hash();
    in_hash_valid = 1'b1;
    in_hash_ref = r;
    in_hash_data = d;
    exp_q.push_back({exp_slot, r});
    tick();
    in_hash_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok && out_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic do_reset();
    auto_ret = 1'b0;
    ret_due_q.delete();
    ret_addr_q.delete();
    in_hash_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    #1;
    iss_cyc_q.delete();
    iss_addr_q.delete();
    iss_step_q.delete();
    exp_q.delete();
    exp_iss_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    n_tot++; if (in_hash_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", in_hash_ready); else n_pass++;
    n_tot++; if ({wr_valid, mul_valid, out_valid, err} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {wr_valid, mul_valid, out_valid, err}); else n_pass++;
    n_tot++; if ({wr_addr, wr_data, mul_addr, mul_step, out_addr, out_ref} !== '0) $display("FAIL reset_payload got nonzero want 0"); else n_pass++;
    rst = 1'b0;
    #1;
    n_tot++; if (in_hash_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_hash_ready); else n_pass++;
  endtask

  task automatic test_single();
    int c0;
    bit ok;
    logic [W_HASH-1:0] d;
    logic [W_IN_MEM+W_T-1:0] e;
    do_reset();
    auto_ret = 1'b1;
    out_ready = 1'b1;
    c0 = cyc;
    drive_req(16'h1234, 6'd0, d);
    n_tot++; if (wr_valid !== 1'b1 || wr_addr !== 6'd0) $display("FAIL single_wr got valid %b addr %0d want 1/0", wr_valid, wr_addr); else n_pass++;
    n_tot++; if (wr_data !== d) $display("FAIL single_wr_data got %h want %h", wr_data, d); else n_pass++;
    wait_out(300, ok);
    n_tot++; if (!ok || cyc != c0 + 74) $display("FAIL single_out_time got ok %0d cycle %0d want cycle %0d", ok, cyc - c0, 74); else n_pass++;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_tot++; if ({out_addr, out_ref} !== e) $display("FAIL single_out got addr %0d ref %h want addr %0d ref %h", out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]); else n_pass++;
    n_tot++; if (iss_cyc_q.size() != 4) $display("FAIL single_issue_count got %0d want 4", iss_cyc_q.size()); else n_pass++;
    for (int k = 0; k < iss_cyc_q.size() && k < 4; k++) begin
      n_tot++;
      if (iss_cyc_q[k] != c0 + 2 + 18*k || iss_addr_q[k] != 0 || iss_step_q[k] != k)
        $display("FAIL single_issue_%0d got cycle %0d addr %0d step %0d want cycle %0d addr 0 step %0d",
                 k, iss_cyc_q[k] - c0, iss_addr_q[k], iss_step_q[k], 2 + 18*k, k);
      else n_pass++;
    end
    tick();
    n_tot++; if (dbg_slot_state[2:0] !== S_FREE) $display("FAIL single_slot0_free got %0d want 0", dbg_slot_state[2:0]); else n_pass++;
    drive_req(16'($urandom_range(0, 65535)), 6'd0, d);
    n_tot++; if (wr_valid !== 1'b1 || wr_addr !== 6'd0) $display("FAIL single_realloc got valid %b addr %0d want 1/0", wr_valid, wr_addr); else n_pass++;
    wait_out(300, ok);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_tot++; if (!ok || {out_addr, out_ref} !== e) $display("FAIL single_realloc_out got ok %0d addr %0d ref %h want addr %0d ref %h", ok, out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]); else n_pass++;
    tick();
  endtask

  task automatic test_fill_cap();
    int errs;
    int r;
    do_reset();
    out_ready = 1'b1;
    errs = 0;
    in_hash_valid = 1'b1;
    for (int i = 0; i < NSLOT; i++) begin
      in_hash_ref = 16'(i);
      in_hash_data = rand_hash();
      tick();
      if (wr_valid !== 1'b1 || wr_addr !== 6'(i)) errs++;
    end
    in_hash_valid = 1'b0;
    n_tot++; if (errs != 0) $display("FAIL fill_wr_addrs got %0d bad writes want 0", errs); else n_pass++;
    n_tot++; if (in_hash_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", in_hash_ready); else n_pass++;
    ticks(30);
    n_tot++; if (iss_cyc_q.size() != MAXI) $display("FAIL fill_issue_count got %0d want %0d", iss_cyc_q.size(), MAXI); else n_pass++;
    errs = 0;
    for (int k = 0; k < iss_addr_q.size(); k++) if (iss_addr_q[k] != k) errs++;
    n_tot++; if (errs != 0) $display("FAIL fill_issue_order got %0d out of order want 0", errs); else n_pass++;
    n_tot++; if (dbg_inflight !== IFW'(MAXI)) $display("FAIL fill_inflight got %0d want %0d", dbg_inflight, MAXI); else n_pass++;
    r = cyc + 1;
    sched_ret(r, 6'd0);
    ticks(12);
    n_tot++; if (iss_cyc_q.size() != MAXI + 1) $display("FAIL fill_after_ret_count got %0d want %0d", iss_cyc_q.size(), MAXI + 1); else n_pass++;
    if (iss_cyc_q.size() > MAXI) begin
      n_tot++;
      if (iss_cyc_q[MAXI] != r + 2 || iss_addr_q[MAXI] != MAXI)
        $display("FAIL fill_after_ret_issue got cycle r+%0d addr %0d want r+2 addr %0d", iss_cyc_q[MAXI] - r, iss_addr_q[MAXI], MAXI);
      else n_pass++;
    end
    n_tot++; if (in_hash_ready !== 1'b0) $display("FAIL fill_ready_hold got %b want 0", in_hash_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [W_HASH-1:0] d;
    logic [W_IN_MEM+W_T-1:0] e;
    logic [W_IN_MEM+8-1:0] ei;
    int k;
    do_reset();
    auto_ret = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_req(16'($urandom_range(0, 65535)), 6'(i), d);
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 3; a++) exp_iss_q.push_back({6'(a), 8'(s)});
    for (int n = 0; n < 3; n++) begin
      wait_out(300, ok);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_tot++;
      if (!ok || {out_addr, out_ref} !== e)
        $display("FAIL rr_out_%0d got ok %0d addr %0d ref %h want addr %0d ref %h", n, ok, out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]);
      else n_pass++;
      tick();
    end
    n_tot++; if (iss_cyc_q.size() != 12) $display("FAIL rr_issue_count got %0d want 12", iss_cyc_q.size()); else n_pass++;
    k = 0;
    while (exp_iss_q.size() > 0 && k < iss_addr_q.size()) begin
      ei = exp_iss_q.pop_front();
      n_tot++;
      if (iss_addr_q[k] != int'(ei[13:8]) || iss_step_q[k] != int'(ei[7:0]))
        $display("FAIL rr_issue_%0d got addr %0d step %0d want addr %0d step %0d", k, iss_addr_q[k], iss_step_q[k], ei[13:8], ei[7:0]);
      else n_pass++;
      k++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W_HASH-1:0] d;
    logic [W_IN_MEM+W_T-1:0] e;
    do_reset();
    auto_ret = 1'b1;
    out_ready = 1'b0;
    drive_req(16'($urandom_range(0, 65535)), 6'd0, d);
    drive_req(16'($urandom_range(0, 65535)), 6'd1, d);
    wait_out(300, ok);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_tot++; if (!ok || {out_addr, out_ref} !== e) $display("FAIL bp_first got ok %0d addr %0d ref %h want addr %0d ref %h", ok, out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tot++;
      if (out_valid !== 1'b1 || {out_addr, out_ref} !== e)
        $display("FAIL bp_hold_%0d got valid %b addr %0d ref %h want 1 addr %0d ref %h", i, out_valid, out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_tot++; if (out_valid !== 1'b1 || {out_addr, out_ref} !== e) $display("FAIL bp_second got valid %b addr %0d ref %h want 1 addr %0d ref %h", out_valid, out_addr, out_ref, e[W_T +: W_IN_MEM], e[W_T-1:0]); else n_pass++;
    n_tot++; if (dbg_slot_state[2:0] !== S_FREE) $display("FAIL bp_slot0_free got %0d want 0", dbg_slot_state[2:0]); else n_pass++;
    tick();
    n_tot++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_same_cycle();
    int r;
    logic [W_HASH-1:0] d;
    do_reset();
    out_ready = 1'b1;
    in_hash_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_hash_ref = 16'(i);
      in_hash_data = rand_hash();
      tick();
    end
    in_hash_valid = 1'b0;
    ticks(20);
    n_tot++; if (dbg_inflight !== IFW'(MAXI)) $display("FAIL same_cap_inflight got %0d want %0d", dbg_inflight, MAXI); else n_pass++;
    r = cyc + 1;
    sched_ret(r, 6'd0);
    ticks(3);
    n_tot++;
    if (iss_cyc_q.size() != MAXI + 1 || mul_valid !== 1'b1 || iss_cyc_q[iss_cyc_q.size()-1] != r + 2)
      $display("FAIL same_cap_issue got count %0d mul_valid %b want count %0d issue at r+2", iss_cyc_q.size(), mul_valid, MAXI + 1);
    else n_pass++;

    do_reset();
    for (int i = 0; i < 5; i++) drive_req(16'(i), 6'(i), d);
    ticks(8);
    n_tot++; if (dbg_inflight !== IFW'(5)) $display("FAIL same_inflight5 got %0d want 5", dbg_inflight); else n_pass++;
    sched_ret(cyc + 1, 6'd0);
    drive_req(16'h0055, 6'd5, d);
    tick();
    n_tot++; if (dbg_inflight !== IFW'(5) || mul_valid !== 1'b1 || mul_addr !== 6'd5) $display("FAIL same_issue_ret got inflight %0d mul %b addr %0d want 5/1/5", dbg_inflight, mul_valid, mul_addr); else n_pass++;
    tick();
    n_tot++; if (dbg_inflight !== IFW'(6) || mul_valid !== 1'b1 || mul_addr !== 6'd0 || mul_step !== 8'd1) $display("FAIL same_reissue got inflight %0d mul %b addr %0d step %0d want 6/1/0/1", dbg_inflight, mul_valid, mul_addr, mul_step); else n_pass++;
  endtask

  task automatic test_error_reset();
    logic [W_HASH-1:0] d;
    int errs;
    do_reset();
    sched_ret(cyc + 1, 6'd9);
    tick();
    n_tot++; if (err !== 1'b0) $display("FAIL err_early got %b want 0", err); else n_pass++;
    tick();
    n_tot++; if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else n_pass++;
    n_tot++; if (dbg_slot_state[27 +: 3] !== S_FREE || dbg_inflight !== '0) $display("FAIL err_state got slot9 %0d inflight %0d want 0/0", dbg_slot_state[27 +: 3], dbg_inflight); else n_pass++;
    ticks(5);
    n_tot++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else n_pass++;

    auto_ret = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_req(16'($urandom_range(0, 65535)), 6'(i), d);
    ticks(20);
    auto_ret = 1'b0;
    ret_due_q.delete();
    ret_addr_q.delete();
    rst = 1'b1;
    #1;
    n_tot++; if ({wr_valid, mul_valid, out_valid, err, in_hash_ready} !== 5'b0) $display("FAIL rst_mid_strobes got %b want 00000", {wr_valid, mul_valid, out_valid, err, in_hash_ready}); else n_pass++;
    n_tot++; if ({wr_addr, wr_data, mul_addr, mul_step, out_addr, out_ref} !== '0 || dbg_inflight !== '0) $display("FAIL rst_mid_payload got nonzero inflight %0d want 0", dbg_inflight); else n_pass++;
    ticks(2);
    rst = 1'b0;
    #1;
    n_tot++; if (in_hash_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", in_hash_ready); else n_pass++;
    errs = 0;
    for (int i = 0; i < NSLOT; i++) if (dbg_slot_state[3*i +: 3] !== S_FREE) errs++;
    ticks(3);
    n_tot++; if (errs != 0 || err !== 1'b0) $display("FAIL rst_mid_slots got %0d non-free err %b want 0/0", errs, err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_cap();
    test_round_robin();
    test_backpressure();
    test_same_cycle();
    test_error_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/shcl_slot_sched.md
# shcl_slot_sched

Slot allocator and issue scheduler for the shared hash/scalar multiplier pipeline of the F1 sigverify model. It accepts tagged hashes and assigns each a slot in the 2^W_IN_MEM-entry input memory. It then issues each slot N_STEPS times into the MUL_D+1-deep multiplier, allowing one pass in flight per slot and at most MAX_INFLIGHT passes in flight overall. Finished slots are presented on a stable output port and are freed only after the consumer handshakes.

## Interface
- W_HASH, 256: hash data width.
- W_IN_MEM, 6: slot address width; NSLOT = 2^W_IN_MEM.
- W_T, 16: request reference tag width.
- MUL_D, 15: multiplier depth parameter; informational only, since the block never assumes return timing.
- N_STEPS, 4: passes per slot; legal range 1..255.
- MAX_INFLIGHT, (MUL_D+1)+6: cap on passes issued but not yet returned.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_hash_data  in  W_HASH  hash to store.
- in_hash_valid  in  1  request valid.
- in_hash_ref  in  W_T  request tag.
- in_hash_ready  out  1  = ~rst & (any slot FREE).
- wr_valid  out  1  slot-memory write strobe.
- wr_addr  out  W_IN_MEM  slot-memory write address.
- wr_data  out  W_HASH  slot-memory write data.
- mul_valid  out  1  pass issue.
- mul_addr  out  W_IN_MEM  slot being issued.
- mul_step  out  8  pass index, 0..N_STEPS-1.
- mul_ret_valid  in  1  pass completion.
- mul_ret_addr  in  W_IN_MEM  slot whose pass completed.
- out_valid  out  1  finished slot available.
- out_ready  in  1  consumer accepts.
- out_addr  out  W_IN_MEM  finished slot.
- out_ref  out  W_T  finished slot's tag.
- err  out  1  sticky protocol error.

## Operation
- Per-slot state: FREE, READY, BUSY, DONE, DRAIN. Each slot also holds an 8-bit step counter and a W_T ref.
- Accept, on in_hash_valid & in_hash_ready:
  - Allocate the lowest-index FREE slot; it goes to READY with step=0 and the ref is stored.
  - Register wr_valid=1, wr_addr=slot, wr_data=in_hash_data.
- Issue, evaluated every cycle from registered state:
  - Eligible when any slot is READY and inflight_q < MAX_INFLIGHT.
  - Pick the first READY slot at or after rr_issue, wrapping modulo NSLOT.
  - Register mul_valid=1, mul_addr=slot, mul_step=step. The slot goes to BUSY, inflight increments and rr_issue becomes slot+1 (wraps).
  - Otherwise register mul_valid=0.
- Return, on mul_ret_valid:
  - If the slot is BUSY: step+1. If step+1 == N_STEPS the slot goes to DONE, otherwise to READY. inflight decrements.
  - If the slot is not BUSY: set err=1 and leave state and inflight unchanged.
- Issue and return in the same cycle: inflight is unchanged.
- Output stage, a register holding out_valid/out_addr/out_ref:
  - Loads when empty, or when out_valid & out_ready in the same cycle.
  - Source is the first DONE slot at or after rr_out (wraps); the chosen slot goes to DRAIN and rr_out becomes slot+1.
  - On an out_valid & out_ready handshake, the DRAIN slot goes to FREE.
  - While out_valid=1 & out_ready=0, out_addr and out_ref stay constant.
- A slot is never reallocated before its DRAIN handshake, so memory at out_addr stays valid until out_ready.
- Reset clears all slots to FREE, inflight to 0, rr pointers to 0, err to 0.

## Timing
- Reset values: every registered output is 0: wr_*, mul_*, out_valid, out_addr, out_ref, err. in_hash_ready is 0 while rst=1 and 1 in the first cycle after release.
- Accept at cycle t:
  - wr_valid at t+1.
  - Earliest mul_valid for that slot at t+2.
  - Earliest in_hash_ready change visible at t+1.
- Return at cycle r re-arms the slot (READY) at r+1; its next mul_valid is at r+2 at the earliest.
- A final return at r gives out_valid at r+2 at the earliest (DONE at r+1, output register loaded at r+2).
- Handshake at cycle h:
  - The slot is FREE at h+1.
  - If another slot is DONE, out_valid stays 1 at h+1 with the new slot; otherwise out_valid=0.
- Throughput: at most 1 accept, 1 issue, 1 return and 1 output per cycle.
- Inflight at MAX_INFLIGHT: no issue is decided in a cycle where inflight_q == MAX_INFLIGHT, even if a return arrives that cycle.
- All slots non-FREE: in_hash_ready=0; an accept needs a prior DRAIN handshake.
- Reset mid-operation clears everything immediately and in-flight returns are lost. A return arriving after reset sets err, so the environment must flush the pipeline before releasing rst.

## Test plan
- Single request:
  - Stimulus: ref=0x1234 accepted at cycle 0; each return given 16 cycles after its issue; out_ready=1.
  - Required: wr at cycle 1, addr 0. mul_valid at 2 (addr 0, step 0), then steps 1, 2, 3 at 2+18k. After the 4th return, out_valid with addr 0, ref 0x1234. Slot 0 is reallocated by the next request.
- Fill / cap:
  - Stimulus: 64 back-to-back accepts, no returns.
  - Required: in_hash_ready=0 after the 64th accept. Exactly 22 mul_valid pulses, then silence until a return. After that return, exactly one more issue, 2 cycles later.
- Round robin:
  - Stimulus: slots 0, 1, 2 READY; each returns 16 cycles after its issue.
  - Required: issue order 0, 1, 2, 0, 1, 2, …; a higher slot is never starved.
- Backpressure:
  - Stimulus: two slots reach DONE; out_ready=0 for 10 cycles.
  - Required: out_addr and out_ref are constant for all 10 cycles. After the handshake the second slot appears the next cycle and the first slot reads FREE.
- Same-cycle events:
  - Stimulus: inflight at 22 and a return at cycle r.
  - Required: no issue decided at r; mul_valid at r+2. With inflight=5, an issue and a return in the same cycle leave inflight at 5.
- Error / reset:
  - Stimulus 1: mul_ret_addr=9 while slot 9 is FREE. Required: err=1 and it stays 1.
  - Stimulus 2: rst pulse mid-run. Required: all registered outputs 0; err cleared; in_hash_ready=1 the cycle after release.
